// File: rtl/key_search_ctrl.sv
// Multi-channel ARC4 key-space search controller: interleaves a key range across
// N_CH check channels and stops at the first key reported valid.

module key_search_lane #(
    parameter int KEY_W = 24,
    parameter int N_CH  = 2,
    parameter int LANE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [KEY_W-1:0] key_lo,
    input  logic [KEY_W-1:0] key_hi,
    input  logic             ch_rdy,
    input  logic             ch_done,
    output logic             ch_en,
    output logic [KEY_W-1:0] ch_key,
    output logic             busy,
    output logic             retired
);
    localparam logic [KEY_W:0] OFS  = (KEY_W+1)'(LANE);
    localparam logic [KEY_W:0] STEP = (KEY_W+1)'(N_CH);

    // One extra bit so stepping past 2^KEY_W-1 retires the lane instead of wrapping.
    logic [KEY_W:0] nxt;
    logic           rdy_q;

    assign retired = nxt > {1'b0, key_hi};
    assign ch_en   = run & ~busy & ~retired & rdy_q;
    assign ch_key  = nxt[KEY_W-1:0];

    // nxt doubles as the in-flight key; it only advances once the channel reports done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt   <= '0;
            busy  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= ch_rdy;
            if (load) begin
                nxt  <= {1'b0, key_lo} + OFS;
                busy <= 1'b0;
            end else if (ch_en) begin
                busy <= 1'b1;
            end else if (busy && ch_done) begin
                busy <= 1'b0;
                nxt  <= nxt + STEP;
            end
        end
    end
endmodule

module key_search_ctrl #(
    parameter int KEY_W = 24,
    parameter int N_CH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  rdy,
    input  logic [KEY_W-1:0]      key_lo,
    input  logic [KEY_W-1:0]      key_hi,
    input  logic [N_CH-1:0]       ch_rdy,
    output logic [N_CH-1:0]       ch_en,
    output logic [N_CH*KEY_W-1:0] ch_key,
    input  logic [N_CH-1:0]       ch_done,
    input  logic [N_CH-1:0]       ch_valid,
    output logic [KEY_W-1:0]      key,
    output logic                  key_valid
);
    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                  state;
    logic [KEY_W-1:0]            hi_q;
    logic [N_CH-1:0]             busy;
    logic [N_CH-1:0]             retired;
    logic [N_CH-1:0][KEY_W-1:0]  key_a;
    logic                        load;
    logic                        run;
    logic                        found;
    logic [KEY_W-1:0]            found_key;

    assign rdy    = (state == S_IDLE);
    assign load   = rdy & en;
    assign run    = (state == S_RUN);
    assign ch_key = key_a;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        key_search_lane #(.KEY_W(KEY_W), .N_CH(N_CH), .LANE(g)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .run     (run),
            .key_lo  (key_lo),
            .key_hi  (hi_q),
            .ch_rdy  (ch_rdy[g]),
            .ch_done (ch_done[g]),
            .ch_en   (ch_en[g]),
            .ch_key  (key_a[g]),
            .busy    (busy[g]),
            .retired (retired[g])
        );
    end

    // Scan high to low so the lowest valid channel index ends up selected.
    always_comb begin
        found     = 1'b0;
        found_key = '0;
        for (int i = N_CH-1; i >= 0; i--) begin
            if (ch_done[i] && ch_valid[i] && busy[i]) begin
                found     = 1'b1;
                found_key = key_a[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RST;
            hi_q      <= '0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            case (state)
                S_RST:  state <= S_IDLE;
                S_IDLE: begin
                    if (en) begin
                        hi_q      <= key_hi;
                        key       <= '0;
                        key_valid <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (found) begin
                        key       <= found_key;
                        key_valid <= 1'b1;
                        state     <= S_DRAIN;
                    end else if ((&retired) && !(|busy)) begin
                        state <= S_DONE;
                    end
                end
                S_DRAIN: if (!(|busy)) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_RST;
            endcase
        end
    end
endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: two instances (2 and 4 channels) driven by random-latency
// channel models; issued keys are checked against the arithmetic interleave of the range.

module tb_key_search_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        en0 = 1'b0, en1 = 1'b0;
    logic [23:0] lo0 = '0, hi0 = '0, lo1 = '0, hi1 = '0;
    logic        rdy0, rdy1, kv0, kv1;
    logic [23:0] key0, key1;
    logic [1:0]  cen0;
    logic [3:0]  cen1;
    logic [47:0] ck0;
    logic [95:0] ck1;
    logic [5:0]  cen;
    logic [5:0]  crdy = '0, cdone = '0, cvalid = '0;
    assign cen = {cen1, cen0};

    key_search_ctrl #(.KEY_W(24), .N_CH(2)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .rdy(rdy0), .key_lo(lo0), .key_hi(hi0),
        .ch_rdy(crdy[1:0]), .ch_en(cen0), .ch_key(ck0), .ch_done(cdone[1:0]),
        .ch_valid(cvalid[1:0]), .key(key0), .key_valid(kv0));

    key_search_ctrl #(.KEY_W(24), .N_CH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .key_lo(lo1), .key_hi(hi1),
        .ch_rdy(crdy[5:2]), .ch_en(cen1), .ch_key(ck1), .ch_done(cdone[5:2]),
        .ch_valid(cvalid[5:2]), .key(key1), .key_valid(kv1));

    // Channels 0..1 belong to u0, channels 2..5 to u1.
    bit          bsy [6];
    int          cnt [6];
    logic [23:0] cur [6];
    logic [23:0] iss [6][$];
    int          viol [2] = '{0, 0};
    int          last_done [2] = '{0, 0};
    bit          rnd [2] = '{0, 0};
    bit          tgt_en [2] = '{0, 0};
    logic [23:0] tgt_a [2] = '{24'h0, 24'h0};
    logic [23:0] tgt_b [2] = '{24'h0, 24'h0};
    int          cyc = 0;
    int          checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dof(input int c);
        return (c < 2) ? 0 : 1;
    endfunction

    function automatic logic [23:0] keyof(input int c);
        if (c < 2) return ck0[c*24 +: 24];
        return ck1[(c-2)*24 +: 24];
    endfunction

    // Channel model: accepts ch_en while idle and ready, answers after 0..3 extra cycles.
    always @(negedge clk) begin
        for (int c = 0; c < 6; c++) begin
            if (!rst_n) begin
                bsy[c]    <= 1'b0;
                crdy[c]   <= 1'b0;
                cdone[c]  <= 1'b0;
                cvalid[c] <= 1'b0;
            end else begin
                cdone[c]  <= 1'b0;
                cvalid[c] <= 1'b0;
                if (cen[c]) begin
                    if (bsy[c] || !crdy[c] || (dof(c) == 1 ? kv1 : kv0))
                        viol[dof(c)] <= viol[dof(c)] + 1;
                    bsy[c]  <= 1'b1;
                    cur[c]  <= keyof(c);
                    cnt[c]  <= rnd[dof(c)] ? int'($urandom_range(0, 3)) : 1;
                    crdy[c] <= 1'b0;
                    iss[c].push_back(keyof(c));
                end else if (bsy[c]) begin
                    if (cnt[c] == 0) begin
                        cdone[c]  <= 1'b1;
                        cvalid[c] <= tgt_en[dof(c)] &&
                                     (cur[c] == tgt_a[dof(c)] || cur[c] == tgt_b[dof(c)]);
                        bsy[c]    <= 1'b0;
                        last_done[dof(c)] <= cyc;
                    end else begin
                        cnt[c] <= cnt[c] - 1;
                    end
                end else begin
                    crdy[c] <= rnd[dof(c)] ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
        end
    end

    task automatic do_start(input int d, input logic [23:0] lo, input logic [23:0] hi);
        for (int i = 0; i < 50 && !(d == 1 ? rdy1 : rdy0); i++) @(negedge clk);
        if (d == 1) begin en1 = 1'b1; lo1 = lo; hi1 = hi; end
        else        begin en0 = 1'b1; lo0 = lo; hi0 = hi; end
        @(negedge clk);
        en0 = 1'b0;
        en1 = 1'b0;
    endtask

    task automatic do_wait(input int d, output bit ok, output int rc);
        ok = 1'b0;
        rc = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (d == 1 ? rdy1 : rdy0) begin
                ok = 1'b1;
                rc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy0, rdy1} !== 2'b00) begin
            errors++; $display("FAIL reset_rdy: got %b want 00", {rdy0, rdy1});
        end
        checks++;
        if (cen !== 6'b0 || kv0 !== 1'b0 || kv1 !== 1'b0) begin
            errors++; $display("FAIL reset_outs: ch_en %b kv %b%b want 0", cen, kv0, kv1);
        end
        checks++;
        if (key0 !== 24'h0 || ck0 !== 48'h0 || ck1 !== 96'h0) begin
            errors++; $display("FAIL reset_keys: key %h ch_key %h want 0", key0, ck0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b0) begin
            errors++; $display("FAIL rst_state: rdy %b before first clock, want 0", rdy0);
        end
        @(posedge clk); #1;
        checks++;
        if ({rdy0, rdy1} !== 2'b11 || kv0 !== 1'b0 || cen !== 6'b0) begin
            errors++; $display("FAIL release: rdy %b%b kv %b ch_en %b want 11/0/0", rdy0, rdy1, kv0, cen);
        end
        @(negedge clk);
    endtask

    // N_CH=2 over 0..0xFF, a single valid key tgt.
    task automatic test_interleave(input int tgt);
        int base [6];
        int v, rc, w, o, bad, sz;
        bit ok;
        rnd[0] = 1'b1; tgt_en[0] = 1'b1; tgt_a[0] = 24'(tgt); tgt_b[0] = 24'(tgt);
        for (int c = 0; c < 6; c++) base[c] = iss[c].size();
        v = viol[0];
        do_start(0, 24'h0, 24'hFF);
        do_wait(0, ok, rc);
        checks++;
        if (!ok) begin errors++; $display("FAIL interleave_done: no rdy within bound"); end
        checks++;
        if (key0 !== 24'(tgt) || kv0 !== 1'b1) begin
            errors++; $display("FAIL interleave_key: got %h/%b want %h/1", key0, kv0, tgt);
        end
        w = tgt % 2; o = 1 - w; bad = 0;
        sz = iss[w].size() - base[w];
        if (sz != tgt/2 + 1) bad++;
        for (int j = base[w]; j < iss[w].size(); j++)
            if (iss[w][j] !== 24'(w + 2*(j - base[w]))) bad++;
        for (int j = base[o]; j < iss[o].size(); j++)
            if (iss[o][j] !== 24'(o + 2*(j - base[o])) || iss[o][j] > 24'hFF) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL interleave_keys: %0d bad issues (winner ch%0d got %0d keys, want %0d)", bad, w, sz, tgt/2 + 1);
        end
        checks++;
        if (viol[0] != v) begin
            errors++; $display("FAIL interleave_proto: %0d ch_en violations, want 0", viol[0] - v);
        end
        checks++;
        if (rc - last_done[0] != 3) begin
            errors++; $display("FAIL interleave_timing: rdy %0d cycles after last done, want 3", rc - last_done[0]);
        end
    endtask

    // N_CH=4 over 0x10..0x1F with no valid key; optionally pulse en mid-run.
    task automatic test_exhaust(input bit pulse);
        int base [6];
        int v, rc, bad;
        bit ok;
        rnd[1] = 1'b1; tgt_en[1] = 1'b0;
        for (int c = 0; c < 6; c++) base[c] = iss[c].size();
        v = viol[1];
        do_start(1, 24'h10, 24'h1F);
        if (pulse) begin
            repeat (4) @(negedge clk);
            checks++;
            if (rdy1 !== 1'b0) begin errors++; $display("FAIL ignore_busy: rdy %b mid-run, want 0", rdy1); end
            en1 = 1'b1; lo1 = 24'h0; hi1 = 24'hFF;
            @(negedge clk);
            en1 = 1'b0;
        end
        do_wait(1, ok, rc);
        checks++;
        if (!ok) begin errors++; $display("FAIL exhaust_done: no rdy within bound"); end
        checks++;
        if (kv1 !== 1'b0 || key1 !== 24'h0) begin
            errors++; $display("FAIL exhaust_key: got %h/%b want 000000/0", key1, kv1);
        end
        for (int i = 0; i < 4; i++) begin
            bad = 0;
            if (iss[i+2].size() - base[i+2] != 4) bad++;
            for (int j = base[i+2]; j < iss[i+2].size(); j++)
                if (iss[i+2][j] !== 24'(16 + i + 4*(j - base[i+2]))) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL exhaust_ch%0d: %0d keys with %0d errors, want 4 keys from %h step 4", i, iss[i+2].size() - base[i+2], bad, 16 + i);
            end
        end
        checks++;
        if (viol[1] != v || rc - last_done[1] != 3) begin
            errors++; $display("FAIL exhaust_proto: viol %0d rdy lag %0d, want 0/3", viol[1] - v, rc - last_done[1]);
        end
    endtask

    task automatic test_simultaneous();
        int b0, b1, rc;
        bit ok;
        rnd[0] = 1'b0; tgt_en[0] = 1'b1; tgt_a[0] = 24'h20; tgt_b[0] = 24'h21;
        b0 = iss[0].size(); b1 = iss[1].size();
        do_start(0, 24'h20, 24'h2F);
        do_wait(0, ok, rc);
        checks++;
        if (!ok || key0 !== 24'h20 || kv0 !== 1'b1) begin
            errors++; $display("FAIL simul_key: ok %b got %h/%b want 000020/1", ok, key0, kv0);
        end
        checks++;
        if (iss[0].size() - b0 != 1 || iss[1].size() - b1 != 1 || iss[0][b0] !== 24'h20 || iss[1][b1] !== 24'h21) begin
            errors++; $display("FAIL simul_issue: ch0 %0d keys ch1 %0d keys, want one each 20/21", iss[0].size() - b0, iss[1].size() - b1);
        end
    endtask

    task automatic test_wrap();
        int base [6];
        int rc, n;
        bit ok;
        rnd[1] = 1'b1; tgt_en[1] = 1'b0;
        for (int c = 0; c < 6; c++) base[c] = iss[c].size();
        do_start(1, 24'hFFFFFE, 24'hFFFFFF);
        do_wait(1, ok, rc);
        checks++;
        if (!ok || kv1 !== 1'b0) begin errors++; $display("FAIL wrap_done: ok %b kv %b want 1/0", ok, kv1); end
        checks++;
        if (iss[2].size() - base[2] != 1 || iss[3].size() - base[3] != 1 ||
            iss[4].size() != base[4] || iss[5].size() != base[5] ||
            iss[2][base[2]] !== 24'hFFFFFE || iss[3][base[3]] !== 24'hFFFFFF) begin
            errors++; $display("FAIL wrap_issue: counts %0d %0d %0d %0d want 1 1 0 0", iss[2].size() - base[2], iss[3].size() - base[3], iss[4].size() - base[4], iss[5].size() - base[5]);
        end
        for (int c = 0; c < 6; c++) base[c] = iss[c].size();
        do_start(1, 24'h5, 24'h3);
        do_wait(1, ok, rc);
        n = 0;
        for (int c = 2; c < 6; c++) n += iss[c].size() - base[c];
        checks++;
        if (!ok || kv1 !== 1'b0 || n != 0) begin
            errors++; $display("FAIL empty_range: ok %b kv %b issued %0d want 1/0/0", ok, kv1, n);
        end
    endtask

    task automatic test_reset_mid();
        rnd[0] = 1'b1; tgt_en[0] = 1'b1; tgt_a[0] = 24'h80; tgt_b[0] = 24'h80;
        do_start(0, 24'h0, 24'hFF);
        repeat (12) @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0) begin errors++; $display("FAIL mid_running: rdy %b want 0", rdy0); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cen !== 6'b0 || kv0 !== 1'b0 || key0 !== 24'h0 || rdy0 !== 1'b0 || ck0 !== 48'h0) begin
            errors++; $display("FAIL mid_reset: ch_en %b kv %b key %h rdy %b want all 0", cen, kv0, key0, rdy0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_interleave(1);
        test_exhaust(1'b0);
        test_simultaneous();
        test_wrap();
        test_interleave(8'h80);
        test_reset_mid();
        test_interleave(1);
        test_exhaust(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_search_ctrl.md
# key_search_ctrl

Parametrised key-space search controller for the ARC4 cracking datapath. It partitions a key range across N_CH decrypt/check channels by interleaving, issues candidate keys through the codebase's rdy/en handshake, and collects per-channel done/valid results. It stops at the first key whose plaintext is reported valid and holds that key for display. It generalises the single-engine crack flow to multiple channels, an arbitrary key width, and a caller-supplied search range.

## Interface
- KEY_W, 24: key width in bits (8..32).
- N_CH, 2: number of channels (1..8).
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  controller is idle and accepts en.
- key_lo  in  KEY_W  first key of the range; sampled with en.
- key_hi  in  KEY_W  last key of the range, inclusive; sampled with en.
- ch_rdy  in  N_CH  channel i is idle and accepts ch_en[i].
- ch_en  out  N_CH  one-cycle start pulse to channel i.
- ch_key  out  N_CH*KEY_W  candidate key for channel i, in bits [i*KEY_W +: KEY_W]; stable from ch_en until ch_done.
- ch_done  in  N_CH  one-cycle pulse: channel i has finished its current key.
- ch_valid  in  N_CH  qualifies ch_done[i]; 1 means the plaintext passed the check.
- key  out  KEY_W  found key, held until the next accepted en.
- key_valid  out  1  1 means key holds a found key; 0 means nothing found or not yet run.

## Operation
- States: RST, IDLE, RUN, DRAIN, DONE.
- Reset (asynchronous): state=RST, rdy=0, ch_en=0, ch_key=0, key=0, key_valid=0, all busy and retired flags cleared.
- RST -> IDLE unconditionally on the first clock after reset release. rdy=1 in IDLE.
- IDLE with en=1: latch key_lo and key_hi; set next_i = key_lo + i for every channel; clear key_valid and key; go to RUN; rdy=0. en while rdy=0 is ignored.
- Channel i is retired once next_i > key_hi. The compare is done at KEY_W+1 bits, so wrap past 2^KEY_W-1 also retires the channel; the key never wraps.
- RUN, per channel:
  - If not busy, not retired, and ch_rdy[i]=1: pulse ch_en[i] for one cycle, set ch_key_i = next_i, next_i += N_CH, set busy_i.
  - On ch_done[i]: clear busy_i. ch_done on a non-busy channel is ignored.
- Found: in RUN, any ch_done[i] & ch_valid[i] latches key = ch_key_i and key_valid=1.
  - Simultaneous valid results: the lowest channel index wins.
  - State goes to DRAIN and no further ch_en is issued.
- DRAIN: wait until all busy flags are clear. Results from the draining channels are discarded, including valid ones.
- RUN -> DONE when every channel is retired and none is busy (range exhausted); key_valid stays 0.
- DRAIN -> DONE when no channel is busy.
- DONE -> IDLE on the next clock. rdy=1 again and key/key_valid are held.
- key_hi < key_lo: all channels retire at start. No ch_en is issued; the controller ends with key_valid=0.
- N_CH=1 degenerates to a sequential search of key_lo..key_hi.

## Timing
- en accepted at edge T: rdy=0 from T. The earliest ch_en is asserted in the cycle after T, for channels with ch_rdy=1.
- ch_en is combinational from registered state and registered ch_rdy sampling. It is at most one pulse per channel per key and never re-asserts while busy_i=1.
- A channel may receive a new ch_en in the cycle after its ch_done, provided ch_rdy is high.
- Valid ch_done at edge T: key and key_valid are updated at T, and ch_en is 0 from T onward.
- If nothing is busy at T, DONE follows at T+1 and rdy=1 at T+2.
- Exhaustion: the last ch_done at edge T gives DONE at T+1 and rdy=1 at T+2.
- Reset asserted mid-RUN or mid-DRAIN: outputs return to reset values immediately. Channels are expected to be reset by the same rst_n.

## Test plan
- Reset, then release: rdy=0 during reset, rdy=1 one clock after release, key_valid=0, ch_en=0.
- N_CH=2, KEY_W=24, range 0..0xFF, channel model valid only for key 0x000001:
  - ch 0 receives 0,2,4,…; ch 1 receives 1,3,5,….
  - Result: key=0x000001, key_valid=1, no ch_en after the valid done, rdy=1 two cycles after the drain completes.
- N_CH=4, range 0x10..0x1F, no valid key: each channel receives exactly 4 keys (i+0x10 step 4); the search ends with key_valid=0 and rdy=1.
- N_CH=2, channels 0 and 1 report valid in the same cycle with keys 0x20 and 0x21: key=0x20.
- Range 0xFFFFFE..0xFFFFFF with N_CH=4 (wrap check): only keys 0xFFFFFE and 0xFFFFFF are issued, no key 0x000000 is issued, and the search terminates. Also key_hi<key_lo (5..3): no ch_en, key_valid=0.
- rst_n dropped mid-RUN with channels busy: ch_en=0 and key_valid=0 immediately. A new run after release repeats the earlier results, and en pulsed while rdy=0 has no effect.
